// File: rtl/spi_burst_fsm.sv
// SPI slave burst controller: sequences header capture, address load,
// memory read/write strobes and MISO drive for one SPI chip-select frame.
// Optional macro SPI_BURST_EN: when defined, a frame may carry any number
// of consecutive data words with an address increment between words.
// When undefined, one word per frame; INC_R/INC_W are unreachable and
// addr_inc is tied low.
module spi_burst_fsm #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk_rise,
  input  logic       cs,
  input  logic       rw_bit,
  output logic       ad_we,
  output logic       sr_we,
  output logic       miso_buff,
  output logic       dm_we,
  output logic       addr_inc,
  output logic       busy,
  output logic [3:0] state
);

  localparam int unsigned HDR_W   = ADDR_W + 1;
  localparam int unsigned CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    GET    = 4'd1,
    GOT    = 4'd2,
    READ   = 4'd3,
    READ2  = 4'd4,
    READ3  = 4'd5,
    WRITE  = 4'd6,
    WRITE2 = 4'd7,
    DONE   = 4'd8,
    INC_R  = 4'd9,
    INC_W  = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             counting;
  logic             hdr_full, word_full;

  logic ad_we_q,     ad_we_d;
  logic sr_we_q,     sr_we_d;
  logic miso_buff_q, miso_buff_d;
  logic dm_we_q,     dm_we_d;
  logic busy_q,      busy_d;

  assign counting  = (state_q == GET) || (state_q == READ3) || (state_q == WRITE);
  assign hdr_full  = (cnt_q == CNT_W'(HDR_W));
  assign word_full = (cnt_q == CNT_W'(DATA_W));

  // Next-state and bit-counter logic; cs=1 overrides every other transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    // Saturating count so the counter can never wrap back into a threshold
    if (counting && sclk_rise && (cnt_q != CNT_W'(CNT_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE:   if (!cs) state_d = GET;
      GET:    if (hdr_full) state_d = GOT;
      GOT:    state_d = rw_bit ? READ : WRITE;
      READ:   state_d = READ2;
      READ2:  state_d = READ3;
`ifdef SPI_BURST_EN
      READ3:  if (word_full) state_d = INC_R;
      WRITE2: state_d = INC_W;
      INC_R:  state_d = READ;
      INC_W:  state_d = WRITE;
`else
      READ3:  if (word_full) state_d = DONE;
      WRITE2: state_d = DONE;
      INC_R:  state_d = IDLE;
      INC_W:  state_d = IDLE;
`endif
      WRITE:  if (word_full) state_d = WRITE2;
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (cs) begin
      state_d = IDLE;
    end

    // Every state change starts a fresh bit count
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Moore output decode of the upcoming state, registered alongside it
  always_comb begin
    ad_we_d     = 1'b0;
    sr_we_d     = 1'b0;
    miso_buff_d = 1'b0;
    dm_we_d     = 1'b0;
    busy_d      = 1'b0;
    ad_we_d     = (state_d == GOT);
    sr_we_d     = (state_d == READ2);
    miso_buff_d = (state_d == READ3);
    dm_we_d     = (state_d == WRITE2);
    busy_d      = (state_d != IDLE);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ad_we_q     <= 1'b0;
      sr_we_q     <= 1'b0;
      miso_buff_q <= 1'b0;
      dm_we_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ad_we_q     <= ad_we_d;
      sr_we_q     <= sr_we_d;
      miso_buff_q <= miso_buff_d;
      dm_we_q     <= dm_we_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_BURST_EN
  logic addr_inc_q, addr_inc_d;

  // Address increment strobe between burst words
  always_comb begin
    addr_inc_d = 1'b0;
    addr_inc_d = (state_d == INC_R) || (state_d == INC_W);
  end

  // Registered address increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_inc_q <= 1'b0;
    end else begin
      addr_inc_q <= addr_inc_d;
    end
  end

  assign addr_inc = addr_inc_q;
`else
  assign addr_inc = 1'b0;
`endif

  assign ad_we     = ad_we_q;
  assign sr_we     = sr_we_q;
  assign miso_buff = miso_buff_q;
  assign dm_we     = dm_we_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spi_burst_fsm.sv
// Randomized frame-level bench for spi_burst_fsm (default 7/8 instance and a
// 15/16 instance sharing stimulus). Honors SPI_BURST_EN like the design.
module tb_spi_burst_fsm;

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, sclk_rise, cs, rw_bit;

  logic       ad1, sr1, mi1, dm1, inc1, bz1;
  logic [3:0] st1;
  logic       ad2, sr2, mi2, dm2, inc2, bz2;
  logic [3:0] st2;

  logic       sel2;
  logic       o_ad_we, o_sr_we, o_miso, o_dm_we, o_inc, o_busy;
  logic [3:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ad = 0, n_sr = 0, n_dm = 0, n_inc = 0, n_idm = 0, n_busy_err = 0;
  bit prev_dm = 1'b0;

  always #5 clk = ~clk;

  spi_burst_fsm #(.ADDR_W(7), .DATA_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .sclk_rise(sclk_rise), .cs(cs), .rw_bit(rw_bit),
    .ad_we(ad1), .sr_we(sr1), .miso_buff(mi1), .dm_we(dm1), .addr_inc(inc1),
    .busy(bz1), .state(st1)
  );

  spi_burst_fsm #(.ADDR_W(15), .DATA_W(16)) u_dut_wide (
    .clk(clk), .reset_n(reset_n), .sclk_rise(sclk_rise), .cs(cs), .rw_bit(rw_bit),
    .ad_we(ad2), .sr_we(sr2), .miso_buff(mi2), .dm_we(dm2), .addr_inc(inc2),
    .busy(bz2), .state(st2)
  );

  assign o_ad_we = sel2 ? ad2  : ad1;
  assign o_sr_we = sel2 ? sr2  : sr1;
  assign o_miso  = sel2 ? mi2  : mi1;
  assign o_dm_we = sel2 ? dm2  : dm1;
  assign o_inc   = sel2 ? inc2 : inc1;
  assign o_busy  = sel2 ? bz2  : bz1;
  assign o_state = sel2 ? st2  : st1;

  // Pulse accounting on the selected instance
  always @(negedge clk) begin
    if (o_ad_we) n_ad++;
    if (o_sr_we) n_sr++;
    if (o_dm_we) n_dm++;
    if (o_inc)   n_inc++;
    if (o_inc && prev_dm) n_idm++;
    prev_dm = o_dm_we;
    if (reset_n && (o_busy != (o_state != 4'd0))) n_busy_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One sclk_rise pulse sampled by the next posedge, then gap idle cycles
  task automatic rise(input int gap);
    sclk_rise = 1'b1;
    step();
    sclk_rise = 1'b0;
    repeat (gap) step();
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) rise((i == n - 1) ? 0 : int'($urandom_range(0, 2)));
  endtask

  task automatic all_zero(input string tag);
    chk(tag, 32'({o_ad_we, o_sr_we, o_miso, o_dm_we, o_inc, o_busy, o_state}), 32'd0);
  endtask

  // One cs frame: header, then k full words or a partial word of part bits
  task automatic frame(input int aw, input int dw, input bit rw, input int k, input int part);
    int a0, s0, d0, i0, x0, ex;
    bit act, ab;
    a0 = n_ad; s0 = n_sr; d0 = n_dm; i0 = n_inc; x0 = n_idm;

    rises(int'($urandom_range(0, 2)));
    chk("idle_noise_state", 32'(o_state), 32'd0);

    rw_bit = rw;
    cs = 1'b0;
    step();
    chk("enter_get", 32'(o_state), 32'd1);
    chk("busy_get", 32'(o_busy), 32'd1);

    rises(aw + 1);
    chk("hdr_wait_state", 32'(o_state), 32'd1);
    chk("hdr_wait_ad", 32'(o_ad_we), 32'd0);
    step();
    chk("got_state", 32'(o_state), 32'd2);
    chk("got_ad_we", 32'(o_ad_we), 32'd1);
    step();
    chk("after_got_ad", 32'(o_ad_we), 32'd0);
    chk("after_got_state", 32'(o_state), rw ? 32'd3 : 32'd6);
    if (rw) begin
      step();
      chk("read2_state", 32'(o_state), 32'd4);
      chk("read2_sr_we", 32'(o_sr_we), 32'd1);
      step();
      chk("read3_state", 32'(o_state), 32'd5);
      chk("read3_miso", 32'(o_miso), 32'd1);
    end

    if (part > 0) begin
      rises(part);
      chk("partial_state", 32'(o_state), rw ? 32'd5 : 32'd6);
      chk("partial_dm", 32'(o_dm_we), 32'd0);
    end else begin
      for (int w = 0; w < k; w++) begin
        act = BURST || (w == 0);
        ab  = act && BURST;
        rises(dw);
        if (!rw) begin
          chk("w_last_state", 32'(o_state), act ? 32'd6 : 32'd8);
          chk("w_last_dm", 32'(o_dm_we), 32'd0);
          step();
          chk("w2_state", 32'(o_state), act ? 32'd7 : 32'd8);
          chk("w2_dm_we", 32'(o_dm_we), 32'(act));
          step();
          chk("w_post_state", 32'(o_state), ab ? 32'd10 : 32'd8);
          chk("w_post_inc", 32'(o_inc), 32'(ab));
          chk("w_post_dm", 32'(o_dm_we), 32'd0);
          step();
          chk("w_next_state", 32'(o_state), ab ? 32'd6 : 32'd8);
        end else begin
          chk("r_last_state", 32'(o_state), act ? 32'd5 : 32'd8);
          chk("r_last_miso", 32'(o_miso), 32'(act));
          step();
          chk("r_end_state", 32'(o_state), ab ? 32'd9 : 32'd8);
          chk("r_end_miso", 32'(o_miso), 32'd0);
          chk("r_end_inc", 32'(o_inc), 32'(ab));
          step();
          chk("r_re_state", 32'(o_state), ab ? 32'd3 : 32'd8);
          step();
          chk("r_re2_state", 32'(o_state), ab ? 32'd4 : 32'd8);
          chk("r_re2_sr_we", 32'(o_sr_we), 32'(ab));
          step();
          chk("r_re3_state", 32'(o_state), ab ? 32'd5 : 32'd8);
          chk("r_re3_miso", 32'(o_miso), 32'(ab));
        end
      end
      ex = int'($urandom_range(0, 3));
      rises(ex);
      step();
      chk("hold_state", 32'(o_state), BURST ? (rw ? 32'd5 : 32'd6) : 32'd8);
    end

    cs = 1'b1;
    step();
    all_zero("cs_release_idle");
    rw_bit = 1'b0;

    chk("cnt_ad_we", 32'(n_ad - a0), 32'd1);
    chk("cnt_dm_we", 32'(n_dm - d0), (rw || part > 0) ? 32'd0 : (BURST ? 32'(k) : 32'd1));
    chk("cnt_sr_we", 32'(n_sr - s0), !rw ? 32'd0 : ((part > 0 || !BURST) ? 32'd1 : 32'(k + 1)));
    chk("cnt_addr_inc", 32'(n_inc - i0), (BURST && part == 0) ? 32'(k) : 32'd0);
    chk("cnt_inc_after_dm", 32'(n_idm - x0), (BURST && !rw && part == 0) ? 32'(k) : 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b1; sclk_rise = 1'b0; rw_bit = 1'b0; sel2 = 1'b0;
    repeat (3) step();
    all_zero("reset_outputs");
    reset_n = 1'b1;
    step();
    all_zero("idle_after_reset");

    // Directed: full write, full read, partial write after 5 bits
    frame(7, 8, 1'b0, 1, 0);
    frame(7, 8, 1'b1, 1, 0);
    frame(7, 8, 1'b0, 1, 5);
    frame(7, 8, 1'b0, 3, 0);
    frame(7, 8, 1'b1, 3, 0);

    for (int t = 0; t < 14; t++) begin
      bit r;
      int kk, pp;
      r  = 1'($urandom_range(0, 1));
      kk = int'($urandom_range(1, 3));
      pp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      frame(7, 8, r, kk, pp);
    end

    // Asynchronous reset mid-write with 5 data bits counted
    cs = 1'b0; rw_bit = 1'b0;
    step();
    rises(8);
    step(); step();
    chk("pre_rst_state", 32'(o_state), 32'd6);
    rises(5);
    chk("pre_rst_write", 32'(o_state), 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    all_zero("async_reset");
    cs = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    all_zero("post_reset_idle");

    // Wide instance: 16-bit header and 16-bit words
    sel2 = 1'b1;
    step();
    frame(15, 16, 1'b0, 1, 0);
    frame(15, 16, 1'b1, 1, 0);
    frame(15, 16, 1'b0, 1, 9);
    sel2 = 1'b0;
    step();

    chk("busy_tracks_state", 32'(n_busy_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
